// File: rtl/dp_ctrl_pkg.sv
// Shared codes, FSM states and request legality for the bus datapath sequencer.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package dp_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_MOV = 2'b01,
        OP_ADD = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    // Code value doubles as the bit index in the one-hot strobe vectors.
    typedef enum logic [1:0] {
        REG_RA = 2'b00,
        REG_RB = 2'b01,
        REG_R0 = 2'b10,
        REG_RZ = 2'b11
    } reg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_DONE,
        ST_ERR
    } state_t;

    // RA is the adder's fixed operand and RZ its result, so neither is a
    // legal MOV/ADD destination; ADD from RZ would read and write RZ at once.
    function automatic logic is_legal(op_t op, reg_t src, reg_t dst);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LDI:  ok = 1'b1;
            OP_MOV:  ok = (dst == REG_RB || dst == REG_R0) && (src != dst);
            OP_ADD:  ok = (dst == REG_RB || dst == REG_R0) && (src != REG_RZ);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dp_strobe_decode.sv
// Turns a register code plus enable into a one-hot strobe vector (RA,RB,R0,RZ).
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module dp_strobe_decode
    import dp_ctrl_pkg::*;
(
    input  reg_t       code,
    input  logic       en,
    output logic [3:0] vec
);

    // One bit per register, nothing when disabled.
    always_comb begin
        vec = 4'b0000;
        if (en) begin
            case (code)
                REG_RA:  vec = 4'b0001;
                REG_RB:  vec = 4'b0010;
                REG_R0:  vec = 4'b0100;
                REG_RZ:  vec = 4'b1000;
                default: vec = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/dp_sequencer.sv
// Control-step FSM issuing bus drive/load strobes for LDI, MOV and ADD micro-ops.
// Latency: ack 1 cycle after req; done 1+steps*(SETTLE_CYCLES+1) cycles after req.
// Backpressure: req is only sampled in IDLE; busy stays high until back in IDLE.
module dp_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 0
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       req,
    input  logic [1:0] op,
    input  logic [1:0] src,
    input  logic [1:0] dst,
    output logic       ack,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       RZout,
    output logic       RAout,
    output logic       RBout,
    output logic       R0out,
    output logic       RZin,
    output logic       RAin,
    output logic       RBin,
    output logic       R0in
);

    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    op_t           op_q;
    reg_t          src_q, dst_q;
    logic          last;

    logic          drv_en, ld_en;
    reg_t          drv_code, ld_code;
    logic [3:0]    drv_vec, ld_vec;

    assign last = (cnt == CNT_LAST);

    // State, settle counter and latched micro-op; counter restarts on every state change.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= OP_LDI;
            src_q <= REG_RA;
            dst_q <= REG_RA;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (state == ST_T1 || state == ST_T2)
                cnt <= cnt + 1'b1;
            if (state == ST_IDLE && req) begin
                op_q  <= op_t'(op);
                src_q <= reg_t'(src);
                dst_q <= reg_t'(dst);
            end
        end
    end

    // Next state plus Moore decode of handshake and strobe selects from registered state only.
    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        drv_en    = 1'b0;
        drv_code  = REG_RA;
        ld_en     = 1'b0;
        ld_code   = REG_RA;
        case (state)
            ST_IDLE: begin
                if (req)
                    state_nxt = is_legal(op_t'(op), reg_t'(src), reg_t'(dst)) ? ST_T1 : ST_ERR;
            end
            ST_T1: begin
                ack      = (cnt == '0);
                // LDI loads RA from the immediate path, so nothing drives the bus.
                drv_en   = (op_q != OP_LDI);
                drv_code = src_q;
                ld_en    = last;
                ld_code  = (op_q == OP_LDI) ? REG_RA : (op_q == OP_ADD) ? REG_RZ : dst_q;
                if (last)
                    state_nxt = (op_q == OP_ADD) ? ST_T2 : ST_DONE;
            end
            ST_T2: begin
                drv_en   = 1'b1;
                drv_code = REG_RZ;
                ld_en    = last;
                ld_code  = dst_q;
                if (last)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                ack       = 1'b1;
                err       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A single drive code guarantees at most one bus driver per cycle.
    dp_strobe_decode u_drv (.code(drv_code), .en(drv_en), .vec(drv_vec));
    dp_strobe_decode u_ld  (.code(ld_code),  .en(ld_en),  .vec(ld_vec));

    assign RAout = drv_vec[0];
    assign RBout = drv_vec[1];
    assign R0out = drv_vec[2];
    assign RZout = drv_vec[3];
    assign RAin  = ld_vec[0];
    assign RBin  = ld_vec[1];
    assign R0in  = ld_vec[2];
    assign RZin  = ld_vec[3];

endmodule

// File: tb/tb_dp_sequencer.sv
module tb_dp_sequencer;

    typedef logic [11:0] sched_q_t [$];

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance a: SETTLE_CYCLES=0, instance b: SETTLE_CYCLES=2.
    logic       clear_a, req_a, clear_b, req_b;
    logic [1:0] op_a, src_a, dst_a, op_b, src_b, dst_b;
    logic ack_a, busy_a, done_a, err_a, RZout_a, RAout_a, RBout_a, R0out_a, RZin_a, RAin_a, RBin_a, R0in_a;
    logic ack_b, busy_b, done_b, err_b, RZout_b, RAout_b, RBout_b, R0out_b, RZin_b, RAin_b, RBin_b, R0in_b;

    dp_sequencer #(.SETTLE_CYCLES(0)) dut_a (
        .clock(clock), .clear(clear_a), .req(req_a), .op(op_a), .src(src_a), .dst(dst_a),
        .ack(ack_a), .busy(busy_a), .done(done_a), .err(err_a),
        .RZout(RZout_a), .RAout(RAout_a), .RBout(RBout_a), .R0out(R0out_a),
        .RZin(RZin_a), .RAin(RAin_a), .RBin(RBin_a), .R0in(R0in_a));

    dp_sequencer #(.SETTLE_CYCLES(2)) dut_b (
        .clock(clock), .clear(clear_b), .req(req_b), .op(op_b), .src(src_b), .dst(dst_b),
        .ack(ack_b), .busy(busy_b), .done(done_b), .err(err_b),
        .RZout(RZout_b), .RAout(RAout_b), .RBout(RBout_b), .R0out(R0out_b),
        .RZin(RZin_b), .RAin(RAin_b), .RBin(RBin_b), .R0in(R0in_b));

    // Packed view: {ack,busy,done,err, out[RZ,R0,RB,RA], in[RZ,R0,RB,RA]}
    logic [11:0] o_a, o_b;
    assign o_a = {ack_a, busy_a, done_a, err_a, RZout_a, R0out_a, RBout_a, RAout_a, RZin_a, R0in_a, RBin_a, RAin_a};
    assign o_b = {ack_b, busy_b, done_b, err_b, RZout_b, R0out_b, RBout_b, RAout_b, RZin_b, R0in_b, RBin_b, RAin_b};

    int pass_cnt = 0;
    int total_cnt = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: a micro-op is a list of (driver, loaded register) steps; each step
    // lasts n+1 cycles with the load only in its last cycle, then one done cycle.
    function automatic sched_q_t sched(int n, logic [1:0] op, logic [1:0] src, logic [1:0] dst);
        sched_q_t q;
        logic [3:0] drv [2];
        logic [3:0] ld [2];
        int steps;
        logic legal;
        legal = 1'b0;
        if (op == 2'd0) legal = 1'b1;
        if (op == 2'd1) legal = (dst == 2'd1 || dst == 2'd2) && (src != dst);
        if (op == 2'd2) legal = (dst == 2'd1 || dst == 2'd2) && (src != 2'd3);
        if (!legal) begin
            q.push_back(12'hD00);
            return q;
        end
        drv[0] = 4'b0000; ld[0] = 4'b0001; drv[1] = 4'b0000; ld[1] = 4'b0000; steps = 1;
        if (op == 2'd1) begin drv[0] = 4'b0001 << src; ld[0] = 4'b0001 << dst; end
        if (op == 2'd2) begin
            steps = 2;
            drv[0] = 4'b0001 << src; ld[0] = 4'b1000;
            drv[1] = 4'b1000;        ld[1] = 4'b0001 << dst;
        end
        for (int s = 0; s < steps; s++)
            for (int c = 0; c <= n; c++)
                q.push_back({(s == 0 && c == 0), 1'b1, 2'b00, drv[s], (c == n) ? ld[s] : 4'b0000});
        q.push_back(12'h600);
        return q;
    endfunction

    sched_q_t q_a, q_b;

    // Model advance: clear flushes, idle + req starts a new schedule, else consume one cycle.
    always @(posedge clock) begin
        if (clear_a) q_a.delete();
        else if (q_a.size() == 0) begin if (req_a) q_a = sched(0, op_a, src_a, dst_a); end
        else void'(q_a.pop_front());
        if (clear_b) q_b.delete();
        else if (q_b.size() == 0) begin if (req_b) q_b = sched(2, op_b, src_b, dst_b); end
        else void'(q_b.pop_front());
    end

    // Per-cycle comparison against the model plus the single-driver rule.
    always @(negedge clock) begin
        if (chk_en) begin
            check("model_a", o_a, (q_a.size() > 0) ? q_a[0] : 12'h000);
            check("model_b", o_b, (q_b.size() > 0) ? q_b[0] : 12'h000);
            check("onehot_a", ($countones(o_a[7:4]) <= 1), 1);
            check("onehot_b", ($countones(o_b[7:4]) <= 1), 1);
        end
    end

    // Small datapath driven by the strobes: bus mux, RZ = RA + bus, LDI immediate into RA.
    localparam logic [7:0] IMM = 8'h05;
    logic [7:0] regs_a [4] = '{8'h05, 8'h0A, 8'h00, 8'h00};
    logic [7:0] regs_b [4] = '{8'h05, 8'h0A, 8'h00, 8'h00};
    logic [7:0] bus_a, bus_b;
    always @(negedge clock) begin
        if (chk_en) begin
            bus_a = o_a[4] ? regs_a[0] : o_a[5] ? regs_a[1] : o_a[6] ? regs_a[2] : o_a[7] ? regs_a[3] : 8'h00;
            bus_b = o_b[4] ? regs_b[0] : o_b[5] ? regs_b[1] : o_b[6] ? regs_b[2] : o_b[7] ? regs_b[3] : 8'h00;
            if (o_a[0]) regs_a[0] <= (o_a[7:4] == 4'b0000) ? IMM : bus_a;
            if (o_a[1]) regs_a[1] <= bus_a;
            if (o_a[2]) regs_a[2] <= bus_a;
            if (o_a[3]) regs_a[3] <= regs_a[0] + bus_a;
            if (o_b[0]) regs_b[0] <= (o_b[7:4] == 4'b0000) ? IMM : bus_b;
            if (o_b[1]) regs_b[1] <= bus_b;
            if (o_b[2]) regs_b[2] <= bus_b;
            if (o_b[3]) regs_b[3] <= regs_b[0] + bus_b;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [2:0]  bad_op [3]  = '{3'd1, 3'd2, 3'd3};
    logic [1:0]  bad_src [3] = '{2'd1, 2'd1, 2'd0};
    logic [1:0]  bad_dst [3] = '{2'd1, 2'd0, 2'd1};
    logic [11:0] trace [9];
    int acks [$];

    initial begin
        clear_a = 1'b1; req_a = 1'b1; op_a = 2'd0; src_a = 2'd0; dst_a = 2'd0;
        clear_b = 1'b1; req_b = 1'b1; op_b = 2'd0; src_b = 2'd0; dst_b = 2'd0;

        // Reset with req held high: nothing may start.
        repeat (3) begin
            cyc();
            chk_en = 1'b1;
            #4;
            check("rst_a", o_a, 12'h000);
            check("rst_b", o_b, 12'h000);
        end
        cyc();
        clear_a = 1'b0; req_a = 1'b0; clear_b = 1'b0; req_b = 1'b0;

        // LDI, no settle: ack+RAin at k+1, done at k+2, idle at k+3 (dst ignored).
        cyc(); req_a = 1'b1; op_a = 2'd0; src_a = 2'd3; dst_a = 2'd3;
        cyc(); req_a = 1'b0; #4; check("ldi_k1", o_a, 12'hC01);
        cyc(); #4; check("ldi_k2", o_a, 12'h600);
        cyc(); #4; check("ldi_k3", o_a, 12'h000);

        // Illegal requests: ack+err at k+1 with no strobes, idle at k+2.
        for (int i = 0; i < 3; i++) begin
            cyc(); req_a = 1'b1; op_a = bad_op[i][1:0]; src_a = bad_src[i]; dst_a = bad_dst[i];
            cyc(); req_a = 1'b0; #4; check("illegal_k1", o_a, 12'hD00);
            cyc(); #4; check("illegal_k2", o_a, 12'h000);
        end

        // Back-to-back MOV RA->RB with req held: acks three cycles apart.
        cyc();
        for (int c = 0; c < 11; c++) begin
            if (c > 0) cyc();
            req_a = (c < 7); op_a = 2'd1; src_a = 2'd0; dst_a = 2'd1;
            #4;
            if (ack_a) acks.push_back(c);
        end
        check("b2b_acks", acks.size(), 3);
        if (acks.size() == 3) begin
            check("b2b_gap1", acks[1] - acks[0], 3);
            check("b2b_gap2", acks[2] - acks[1], 3);
        end
        check("b2b_rb", regs_a[1], 8'h05);

        // ADD RB->R0 with two settle cycles per T-state.
        cyc(); req_b = 1'b1; op_b = 2'd2; src_b = 2'd1; dst_b = 2'd2;
        for (int j = 1; j <= 8; j++) begin
            cyc(); req_b = 1'b0; #4;
            trace[j] = o_b;
        end
        check("add_k1", trace[1], 12'hC20);
        check("add_k2", trace[2], 12'h420);
        check("add_k3", trace[3], 12'h428);
        check("add_k4", trace[4], 12'h480);
        check("add_k6", trace[6], 12'h484);
        check("add_k7", trace[7], 12'h600);
        check("add_k8", trace[8], 12'h000);
        check("add_r0", regs_b[2], 8'h0F);

        // ADD RA->R0 cleared in its first T2 cycle: RZ already loaded, R0 untouched.
        cyc(); req_b = 1'b1; op_b = 2'd2; src_b = 2'd0; dst_b = 2'd2;
        for (int j = 1; j <= 4; j++) begin
            cyc();
            if (j == 1) req_b = 1'b0;
            if (j == 4) clear_b = 1'b1;
        end
        cyc(); clear_b = 1'b0; #4; check("clr_k5", o_b, 12'h000);
        cyc(); #4; check("clr_k6", o_b, 12'h000);
        check("clr_r0", regs_b[2], 8'h0F);
        check("clr_rz", regs_b[3], 8'h0A);

        repeat (3) cyc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
